// File: rtl/alarm_ringer_ctrl.sv
// Alarm ringer controller: rings on a rising comparator match, supports a bounded
// number of snoozes, auto-stops after a timeout and waits for the match minute to end.
module alarm_ringer_ctrl #(
  parameter int TIMEOUT_SECS = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ringer_i,
  input  logic       one_second_i,
  input  logic       alarm_enable_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  output logic       sound_alarm_o,
  output logic       beep_o,
  output logic       snooze_active_o,
  output logic [1:0] snoozes_left_o,
  output logic       missed_o,
  output logic [1:0] state_o
);

  // Debug encoding on state_o: 0 idle, 1 ringing, 2 snoozing, 3 done.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RINGING  = 2'd1,
    S_SNOOZING = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [8:0] TIMEOUT_LAST = 9'(TIMEOUT_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST  = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNOOZE_INIT  = 2'(MAX_SNOOZES);

  state_t     state_q, state_d;
  logic [8:0] timer_q, timer_d;
  logic [1:0] snoozes_q, snoozes_d;
  logic       phase_q, phase_d;
  logic       missed_q, missed_d;
  logic       ringer_prev_q;
  logic       start_evt;

  assign start_evt = ringer_i & ~ringer_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      snoozes_q     <= '0;
      phase_q       <= 1'b0;
      missed_q      <= 1'b0;
      ringer_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      snoozes_q     <= snoozes_d;
      phase_q       <= phase_d;
      missed_q      <= missed_d;
      ringer_prev_q <= ringer_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    snoozes_d = snoozes_q;
    phase_d   = phase_q;
    missed_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_evt && alarm_enable_i) begin
          state_d   = S_RINGING;
          timer_d   = '0;
          snoozes_d = SNOOZE_INIT;
          phase_d   = 1'b1;
        end
      end
      S_RINGING: begin
        if (stop_i || !alarm_enable_i) begin
          state_d = S_DONE;
          timer_d = '0;
        end else if (snooze_i && (snoozes_q != 2'd0)) begin
          state_d   = S_SNOOZING;
          timer_d   = '0;
          snoozes_d = snoozes_q - 2'd1;
        end else if (one_second_i) begin
          phase_d = ~phase_q;
          if (timer_q == TIMEOUT_LAST) begin
            state_d  = S_DONE;
            timer_d  = '0;
            missed_d = 1'b1;
          end else begin
            timer_d = timer_q + 9'd1;
          end
        end
      end
      S_SNOOZING: begin
        if (stop_i || !alarm_enable_i) begin
          state_d = S_DONE;
          timer_d = '0;
        end else if (one_second_i) begin
          if (timer_q == SNOOZE_LAST) begin
            state_d = S_RINGING;
            timer_d = '0;
            phase_d = 1'b1;
          end else begin
            timer_d = timer_q + 9'd1;
          end
        end
      end
      S_DONE: begin
        // Hold until the match minute ends so the same match cannot re-trigger.
        if (!ringer_i) begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sound_alarm_o   = (state_q == S_RINGING);
  assign beep_o          = sound_alarm_o & phase_q;
  assign snooze_active_o = (state_q == S_SNOOZING);
  assign snoozes_left_o  = snoozes_q;
  assign missed_o        = missed_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_alarm_ringer_ctrl.sv
// Bench for alarm_ringer_ctrl: directed scenarios then random stimulus, all checked
// against an event-level model of the alarm's behaviour.
module tb_alarm_ringer_ctrl;

  localparam int TO  = 4;
  localparam int SN  = 3;
  localparam int MAX = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ringer_i = 1'b0;
  logic       one_second_i = 1'b0;
  logic       alarm_enable_i = 1'b1;
  logic       snooze_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       sound_alarm_o, beep_o, snooze_active_o, missed_o;
  logic [1:0] snoozes_left_o, state_o;

  int errors = 0;
  int checks = 0;

  // Model: which phase of the alarm event we are in and seconds spent in it.
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_left = 0;
  int m_missed = 0;
  int m_prev = 1;

  alarm_ringer_ctrl #(.TIMEOUT_SECS(TO), .SNOOZE_SECS(SN), .MAX_SNOOZES(MAX)) dut (
    .clk_i(clk), .reset_i(reset_i), .ringer_i(ringer_i), .one_second_i(one_second_i),
    .alarm_enable_i(alarm_enable_i), .snooze_i(snooze_i), .stop_i(stop_i),
    .sound_alarm_o(sound_alarm_o), .beep_o(beep_o), .snooze_active_o(snooze_active_o),
    .snoozes_left_o(snoozes_left_o), .missed_o(missed_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int start;
    if (reset_i) begin
      m_mode = M_IDLE; m_secs = 0; m_left = 0; m_missed = 0; m_prev = 1;
      return;
    end
    start = (ringer_i && !m_prev) ? 1 : 0;
    m_prev = ringer_i ? 1 : 0;
    m_missed = 0;
    case (m_mode)
      M_IDLE: if (start == 1 && alarm_enable_i) begin
        m_mode = M_RING; m_secs = 0; m_left = MAX;
      end
      M_RING: begin
        if (stop_i || !alarm_enable_i) m_mode = M_DONE;
        else if (snooze_i && m_left > 0) begin
          m_mode = M_SNZ; m_secs = 0; m_left = m_left - 1;
        end else if (one_second_i) begin
          m_secs = m_secs + 1;
          if (m_secs == TO) begin m_mode = M_DONE; m_missed = 1; end
        end
      end
      M_SNZ: begin
        if (stop_i || !alarm_enable_i) m_mode = M_DONE;
        else if (one_second_i) begin
          m_secs = m_secs + 1;
          if (m_secs == SN) begin m_mode = M_RING; m_secs = 0; end
        end
      end
      default: if (!ringer_i) m_mode = M_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic ring;
    ring = (m_mode == M_RING);
    chk("sound_alarm", {1'b0, sound_alarm_o}, {1'b0, ring});
    chk("beep", {1'b0, beep_o}, {1'b0, ring && (m_secs % 2 == 0)});
    chk("snooze_active", {1'b0, snooze_active_o}, {1'b0, m_mode == M_SNZ});
    chk("snoozes_left", snoozes_left_o, 2'(m_left));
    chk("missed", {1'b0, missed_o}, {1'b0, m_missed == 1});
    chk("state", state_o, 2'(m_mode));
  endtask

  // One clock: apply pulses, let the DUT and model see the edge, then compare.
  task automatic step(input logic os, input logic sn, input logic st, input logic rst);
    one_second_i = os; snooze_i = sn; stop_i = st; reset_i = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    one_second_i = 1'b0; snooze_i = 1'b0; stop_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Timeout with beep pattern, then DONE until ringer falls.
    ringer_i = 1'b1; idle(1);
    ticks(TO);
    idle(3);
    ringer_i = 1'b0; idle(2);

    // Snooze exhaustion.
    ringer_i = 1'b1; idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SN);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(SN);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(TO);
    ringer_i = 1'b0; idle(2);

    // Stop and snooze together.
    ringer_i = 1'b1; idle(1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    ringer_i = 1'b0; idle(1);

    // Disable while snoozing; start edge while disabled.
    ringer_i = 1'b1; idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    alarm_enable_i = 1'b0; idle(1);
    ringer_i = 1'b0; idle(1);
    ringer_i = 1'b1; idle(3);
    ringer_i = 1'b0; alarm_enable_i = 1'b1; idle(1);

    // Reset during ringing with ringer held high.
    ringer_i = 1'b1; idle(1);
    ticks(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    ringer_i = 1'b0; idle(1);
    ringer_i = 1'b1; idle(2);

    // Snooze coincident with the final timeout tick.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ringer_i = 1'b0; idle(1);
    ringer_i = 1'b1; idle(1);
    ticks(TO - 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(SN + 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ringer_i = 1'b0; idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ringer_i = ~ringer_i;
      if ($urandom_range(0, 39) == 0) alarm_enable_i = ~alarm_enable_i;
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
